// File: rtl/md_unit_pkg.sv
// Shared HILO op codes, default latencies and the mult/div result function
// for the E-stage multiply/divide unit.
package md_unit_pkg;

  localparam logic [3:0] HILO_MULT  = 4'b0000;
  localparam logic [3:0] HILO_DIV   = 4'b0001;
  localparam logic [3:0] HILO_MULTU = 4'b0010;
  localparam logic [3:0] HILO_DIVU  = 4'b0011;
  localparam logic [3:0] HILO_MFHI  = 4'b0100;
  localparam logic [3:0] HILO_MFLO  = 4'b0101;
  localparam logic [3:0] HILO_MTHI  = 4'b0110;
  localparam logic [3:0] HILO_MTLO  = 4'b0111;
  localparam logic [3:0] HILO_NONE  = 4'b1000;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 4;

  typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  // Divide by zero yields wr=0 so HI/LO survive the sequence untouched.
  function automatic md_res_t md_calc(input logic [3:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    md_res_t            r;
    r  = '0;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'd0, a} * {32'd0, b};
    case (op)
      HILO_MULT:  r = '{wr: 1'b1, hi: sp[63:32], lo: sp[31:0]};
      HILO_MULTU: r = '{wr: 1'b1, hi: up[63:32], lo: up[31:0]};
      HILO_DIV: if (b != 32'd0) begin
        r.wr = 1'b1;
        r.lo = 32'($signed(a) / $signed(b));
        r.hi = 32'($signed(a) % $signed(b));
      end
      HILO_DIVU: if (b != 32'd0) begin
        r.wr = 1'b1;
        r.lo = a / b;
        r.hi = a % b;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide sequencer and HI/LO owner: result is computed at issue,
// held pending for a fixed latency, then committed to HI/LO.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  HILO_type,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] hilo_out
);

  md_state_e             state, state_nxt;
  logic [MD_CNT_W-1:0]   cnt;
  md_res_t               pend, res;
  logic                  is_div, last;

  assign res    = md_calc(HILO_type, A, B);
  assign is_div = (HILO_type == HILO_DIV) || (HILO_type == HILO_DIVU);
  assign last   = (cnt == MD_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start) state_nxt = MD_RUN;
      MD_RUN:  if (last)  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    start    = (HILO_type[3:2] == 2'b00);
    busy     = (state == MD_RUN);
    hilo_out = 32'd0;
    if (HILO_type == HILO_MFHI) hilo_out = HI;
    if (HILO_type == HILO_MFLO) hilo_out = LO;
  end

  // Requests arriving during RUN are dropped: only IDLE accepts new work.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      pend <= '0;
      HI   <= 32'd0;
      LO   <= 32'd0;
    end else if (state == MD_IDLE) begin
      if (start) begin
        pend <= res;
        cnt  <= is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
      end else if (HILO_type == HILO_MTHI) begin
        HI <= A;
      end else if (HILO_type == HILO_MTLO) begin
        LO <= A;
      end
    end else begin
      cnt <= cnt - MD_CNT_W'(1);
      if (last && pend.wr) begin
        HI <= pend.hi;
        LO <= pend.lo;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: issued mult/div ops push expected busy length
// and HI/LO into a queue that a negedge monitor checks when busy drops.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  HILO_type;
  logic [31:0] A, B;
  logic        start, busy;
  logic [31:0] HI, LO, hilo_out;

  md_unit dut (
    .clk(clk), .reset(reset), .HILO_type(HILO_type), .A(A), .B(B),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   bcnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks HI/LO once busy falls.
  always @(negedge clk) begin
    if (busy === 1'b1) bcnt++;
    else if (bcnt > 0) begin
      if (q.size() == 0) begin
        checks++; fails++;
        $display("FAIL sb_unexpected: busy fell after %0d cycles, queue empty", bcnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_busy_len", 32'(bcnt), 32'(e.cyc));
        chk("sb_hi", HI, e.hi);
        chk("sb_lo", LO, e.lo);
      end
      bcnt = 0;
    end
  end

  // Presents an op for exactly one cycle, then returns to a bubble.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    HILO_type = op; A = a; B = b;
    @(posedge clk); #1;
    HILO_type = HILO_NONE; A = '0; B = '0;
  endtask

  task automatic md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                    input int cyc, input logic [31:0] hi, input logic [31:0] lo);
    q.push_back('{cyc: cyc, hi: hi, lo: lo});
    HILO_type = op; A = a; B = b;
    #1 chk("start_on_md", 32'(start), 32'd1);
    @(posedge clk); #1;
    HILO_type = HILO_NONE; A = '0; B = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (busy !== 1'b0) begin
      checks++; fails++;
      $display("FAIL wait_idle: busy=%b still high after %0d cycles", busy, n);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; HILO_type = HILO_NONE; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hilo_out", hilo_out, 32'd0);
    chk("rst_start", 32'(start), 32'd0);

    md(HILO_MULT, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    wait_idle();
    HILO_type = HILO_MFHI; #1 chk("mfhi_after_mult", hilo_out, 32'hFFFFFFFF);
    @(posedge clk); #1 HILO_type = HILO_NONE;

    md(HILO_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    wait_idle();
    md(HILO_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle();
    md(HILO_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    wait_idle();
    md(HILO_DIVU, 32'd7, 32'd0, 10, 32'h00000001, 32'hFFFFFFFD);
    wait_idle();

    issue(HILO_MTHI, 32'h12345678, '0);
    chk("mthi_hi", HI, 32'h12345678);
    issue(HILO_MTLO, 32'h9ABCDEF0, '0);
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    HILO_type = HILO_MFLO; #1 chk("mflo_out", hilo_out, 32'h9ABCDEF0);
    HILO_type = HILO_MFHI; #1 chk("mfhi_out", hilo_out, 32'h12345678);
    HILO_type = HILO_NONE; #1 chk("none_out", hilo_out, 32'd0);
    HILO_type = 4'b1111;   #1 chk("undef_out", hilo_out, 32'd0);
    @(posedge clk); #1 HILO_type = HILO_NONE;
    chk("undef_keeps_hi", HI, 32'h12345678);

    // Ops arriving during RUN must not disturb the running mult.
    md(HILO_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);
    @(posedge clk); #1;
    issue(HILO_DIV, 32'd100, 32'd3);
    issue(HILO_MTLO, 32'd1, '0);
    chk("mtlo_ignored_in_run", LO, 32'h9ABCDEF0);
    wait_idle();

    // Reset in RUN cycle 4 aborts the divide.
    md(HILO_DIV, 32'd100, 32'd7, 4, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_late_hi", HI, 32'd0);
    chk("abort_no_late_lo", LO, 32'd0);
    chk("abort_no_late_busy", 32'(busy), 32'd0);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide sequencer and HI/LO register owner for the P6 pipeline.
- Sits in the E stage and consumes the decoder's 4-bit HILO_type code together with the forwarded rs/rt operands.
- Models multi-cycle mult/div latency with a busy counter and performs mthi/mtlo writes.
- Supplies HI/LO read data for mfhi/mflo, and start/busy to the hazard unit so it can stall md/mf/mt instructions behind a running operation.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- HILO_type  input  4  E-stage op code: 0000 mult, 0001 div, 0010 multu, 0011 divu, 0100 mfhi, 0101 mflo, 0110 mthi, 0111 mtlo, 1000 none (bubble).
- A  input  32  rs operand after forwarding.
- B  input  32  rt operand after forwarding.
- start  output  1  combinational; 1 when HILO_type is 0000..0011.
- busy  output  1  registered; 1 while an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- hilo_out  output  32  combinational; HI for mfhi, LO for mflo, otherwise 0.

Behaviour:
- Reset (synchronous, highest priority): HI=0, LO=0, busy=0, counter=0, pending HI/LO=0. Reset mid-operation aborts the operation; no HI/LO update follows.
- States: IDLE (busy=0) and RUN (busy=1). The 4-bit counter is wide enough for both parameters.
- IDLE with start=1 at edge of cycle t:
  - Compute the result from A/B and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy<=1.
- RUN: busy is high for exactly N cycles (t+1..t+N).
  - Each edge in RUN decrements the counter.
  - On the edge where counter==1: busy<=0, HI<=pending_hi, LO<=pending_lo.
  - The new HI/LO value is visible from cycle t+N+1.
- Arithmetic:
  - mult: signed 32x32->64, HI=upper, LO=lower.
  - multu: same, unsigned.
  - div: LO=signed quotient, HI=signed remainder; truncates toward zero, remainder takes the dividend's sign.
  - divu: same, unsigned.
- Divide by zero (B==0): the sequence still runs DIV_CYCLES with busy asserted, but HI/LO are left unchanged at completion.
- mthi/mtlo: in IDLE, HI<=A or LO<=A at the next edge. During RUN they are ignored.
- Ignored while busy: start requests and mthi/mtlo issued in RUN have no effect on counter, pending or HI/LO. The hazard unit stalls on (start|busy) with an md/mf/mt op in D, so this case is a protocol violation that must be harmless.
- hilo_out is purely combinational from the current HI/LO. mf during RUN returns the old value; the hazard unit prevents this case.
- HILO_type 1000 or any undefined code: no state change.
- start stays asserted for the single cycle the op sits in E. The op leaves E the next cycle; only the internal state persists.

Decomposition:
- Add HILO_type code macros to const.v: HILO_MULT, HILO_DIV, HILO_MULTU, HILO_DIVU, HILO_MFHI, HILO_MFLO, HILO_MTHI, HILO_MTLO, HILO_NONE.
- Add default latency macros MD_MULT_CYCLES and MD_DIV_CYCLES to const.v.
- No sub-module: the result calculation is behavioural (*, /, %) inside md_unit, and the counter/FSM is small enough to stay inline.

Test Plan:
- mult A=FFFFFFFD (-3), B=5 -> busy high 5 cycles; then HI=FFFFFFFF, LO=FFFFFFF1; mfhi gives hilo_out=FFFFFFFF.
- multu A=FFFFFFFF, B=2 -> HI=00000001, LO=FFFFFFFE after exactly 5 busy cycles.
- div A=FFFFFFF9 (-7), B=2 -> busy high 10 cycles; LO=FFFFFFFD, HI=FFFFFFFF. divu A=7, B=0 -> busy high 10 cycles; HI/LO keep prior values.
- mthi A=12345678, then mflo after mtlo A=9ABCDEF0 -> HI=12345678 next cycle; hilo_out=9ABCDEF0 for mflo.
- Start mult, then in cycle 2 of RUN present div and mtlo A=1 -> both ignored; mult result lands at cycle t+6; LO is not 1.
- Start div, assert reset in cycle 4 of RUN -> next cycle busy=0, HI=LO=0; no later update occurs.
